// File: rtl/cdb_arbiter_if.sv
// Common Data Bus arbitration interface: per-RS request payloads in, registered CDB broadcast out.
// The slave modport is the arbiter's view and the master modport is the reservation-station side.
interface cdb_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned TAG_W   = 5,
  parameter int unsigned DATA_W  = 32
);
  logic [NUM_REQ-1:0]        in_req;
  logic [NUM_REQ*TAG_W-1:0]  in_tag;
  logic [NUM_REQ*DATA_W-1:0] in_val;
  logic [NUM_REQ*4-1:0]      in_icc;
  logic [NUM_REQ-1:0]        in_icc_we;
  logic                      in_flush;

  logic [NUM_REQ-1:0]        out_grant;
  logic                      out_CDB_broadcast;
  logic [TAG_W-1:0]          out_CDB_tag;
  logic [DATA_W-1:0]         out_CDB_val;
  logic [3:0]                out_ICC_flags;
  logic                      out_ICC_we;
  logic                      out_err_tag;

  modport master (
    output in_req, in_tag, in_val, in_icc, in_icc_we, in_flush,
    input  out_grant, out_CDB_broadcast, out_CDB_tag, out_CDB_val,
           out_ICC_flags, out_ICC_we, out_err_tag
  );

  modport slave (
    input  in_req, in_tag, in_val, in_icc, in_icc_we, in_flush,
    output out_grant, out_CDB_broadcast, out_CDB_tag, out_CDB_val,
           out_ICC_flags, out_ICC_we, out_err_tag
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Round-robin owner of the Common Data Bus: grants one reservation station per cycle
// and drives its tag, value and ICC onto a registered broadcast.
module cdb_arbiter #(
  parameter int unsigned     NUM_REQ     = 4,
  parameter int unsigned     TAG_W       = 5,
  parameter int unsigned     DATA_W      = 32,
  parameter logic [TAG_W-1:0] INVALID_TAG = '1
) (
  input logic          clk,
  input logic          rst,
  cdb_arbiter_if.slave cdb
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]   ptr;
  logic [NUM_REQ-1:0] last_grant;

  logic [TAG_W-1:0]   tags [NUM_REQ];
  logic [DATA_W-1:0]  vals [NUM_REQ];
  logic [3:0]         iccs [NUM_REQ];
  logic [NUM_REQ-1:0] elig;
  logic [NUM_REQ-1:0] bad_req;

  logic               found;
  logic [PTR_W-1:0]   win;
  logic [PTR_W:0]     idx;
  logic [PTR_W-1:0]   ptr_nxt;
  logic [NUM_REQ-1:0] grant_nxt;
  logic [TAG_W-1:0]   win_tag;
  logic [DATA_W-1:0]  win_val;
  logic [3:0]         win_icc;
  logic               win_icc_we;

  // Unpack per-RS slices; the RS that was just granted is masked for one cycle.
  always_comb begin
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      tags[i]    = cdb.in_tag[i*TAG_W +: TAG_W];
      vals[i]    = cdb.in_val[i*DATA_W +: DATA_W];
      iccs[i]    = cdb.in_icc[i*4 +: 4];
      bad_req[i] = cdb.in_req[i] & (tags[i] == INVALID_TAG);
      elig[i]    = cdb.in_req[i] & ~last_grant[i] & (tags[i] != INVALID_TAG);
    end
  end

  // First eligible index at or after ptr, wrapping past NUM_REQ-1 to 0.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      idx = {1'b0, ptr} + (PTR_W+1)'(k);
      if (idx >= (PTR_W+1)'(NUM_REQ)) idx = idx - (PTR_W+1)'(NUM_REQ);
      if (!found && elig[PTR_W'(idx)]) begin
        found = 1'b1;
        win   = PTR_W'(idx);
      end
    end
  end

  always_comb begin
    win_tag    = '0;
    win_val    = '0;
    win_icc    = '0;
    win_icc_we = 1'b0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (PTR_W'(i) == win) begin
        win_tag    = tags[i];
        win_val    = vals[i];
        win_icc    = iccs[i];
        win_icc_we = cdb.in_icc_we[i];
      end
    end
    grant_nxt = NUM_REQ'(1) << win;
    ptr_nxt   = (win == PTR_W'(NUM_REQ - 1)) ? '0 : win + PTR_W'(1);
  end

  // Flush suppresses the broadcast but keeps ptr and the mask so no request is lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr                   <= '0;
      last_grant            <= '0;
      cdb.out_grant         <= '0;
      cdb.out_CDB_broadcast <= 1'b0;
      cdb.out_CDB_tag       <= INVALID_TAG;
      cdb.out_CDB_val       <= '0;
      cdb.out_ICC_flags     <= '0;
      cdb.out_ICC_we        <= 1'b0;
      cdb.out_err_tag       <= 1'b0;
    end else begin
      if (|bad_req) cdb.out_err_tag <= 1'b1;
      if (cdb.in_flush) begin
        cdb.out_grant         <= '0;
        cdb.out_CDB_broadcast <= 1'b0;
        cdb.out_ICC_we        <= 1'b0;
      end else if (found) begin
        ptr                   <= ptr_nxt;
        last_grant            <= grant_nxt;
        cdb.out_grant         <= grant_nxt;
        cdb.out_CDB_broadcast <= 1'b1;
        cdb.out_CDB_tag       <= win_tag;
        cdb.out_CDB_val       <= win_val;
        cdb.out_ICC_flags     <= win_icc;
        cdb.out_ICC_we        <= win_icc_we;
      end else begin
        last_grant            <= '0;
        cdb.out_grant         <= '0;
        cdb.out_CDB_broadcast <= 1'b0;
        cdb.out_ICC_we        <= 1'b0;
      end
    end
  end

endmodule
